// File: rtl/mux_sweep_sequencer_pkg.sv
// Shared types and sizes for the mux sweep sequencer.
package mux_seq_pkg;
  localparam int NUM_COMB = 8;
  localparam int IDX_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/mux_sweep_sequencer_if.sv
// Command/status and mux-facing signals of the sweep sequencer.
interface mux_sweep_sequencer_if;
  logic       start;
  logic       abort;
  logic       loop;
  logic       y_in;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic [7:0] truth;
  logic       valid;

  modport master (
    output start, abort, loop, y_in,
    input  a, b, c, busy, done, truth, valid
  );

  modport slave (
    input  start, abort, loop, y_in,
    output a, b, c, busy, done, truth, valid
  );
endinterface

// File: rtl/mux_sweep_sequencer_dwell_counter.sv
// Counts clocks within one dwell; last flags the sample cycle.
module dwell_counter #(
  parameter int HOLD_CYCLES = 10,
  parameter int HOLD_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic last
);
  logic [HOLD_W-1:0] cnt;

  assign last = en && (cnt == HOLD_W'(HOLD_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (clear || last)  cnt <= '0;
    else if (en)             cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mux_sweep_sequencer.sv
// Steps {a,b,c} through 0..7, samples y_in at the end of each dwell and
// publishes the captured truth vector with a done pulse.
module mux_sweep_sequencer
  import mux_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 10,
  parameter int HOLD_W      = 8
) (
  input logic               clk,
  input logic               rst_n,
  mux_sweep_sequencer_if.slave bus
);
  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [7:0]       shadow, shadow_n;
  logic [7:0]       truth, truth_n;
  logic             done, done_n;
  logic             valid, valid_n;
  logic             last, cnt_en, cnt_clr;

  assign cnt_en  = (state == DRIVE);
  assign cnt_clr = (state != DRIVE);

  dwell_counter #(.HOLD_CYCLES(HOLD_CYCLES), .HOLD_W(HOLD_W)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clr),
    .en    (cnt_en),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      shadow <= 8'h00;
      truth  <= 8'h00;
      done   <= 1'b0;
      valid  <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      shadow <= shadow_n;
      truth  <= truth_n;
      done   <= done_n;
      valid  <= valid_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    shadow_n = shadow;
    truth_n  = truth;
    done_n   = 1'b0;
    valid_n  = valid;
    case (state)
      IDLE: begin
        idx_n = '0;
        if (!bus.abort && bus.start) begin
          state_n  = DRIVE;
          shadow_n = 8'h00;
        end
      end
      DRIVE: begin
        if (bus.abort) begin
          state_n  = IDLE;
          idx_n    = '0;
          shadow_n = 8'h00;
        end else if (last) begin
          shadow_n[idx] = bus.y_in;
          if (idx == IDX_W'(NUM_COMB - 1)) state_n = DONE;
          else                             idx_n   = idx + 1'b1;
        end
      end
      DONE: begin
        // The pulse completes even on abort; abort only suppresses looping.
        truth_n = shadow;
        done_n  = 1'b1;
        valid_n = 1'b1;
        idx_n   = '0;
        state_n = (bus.loop && !bus.abort) ? DRIVE : IDLE;
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  assign {bus.a, bus.b, bus.c} = idx;
  assign bus.busy  = (state != IDLE);
  assign bus.done  = done;
  assign bus.truth = truth;
  assign bus.valid = valid;
endmodule

// File: tb/tb_mux_sweep_sequencer.sv
// Bench for mux_sweep_sequencer: dwell-10 and dwell-1 instances, y_in modelled
// as a truth-table lookup on {a,b,c}.
module tb_mux_sweep_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] mask10, mask1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mux_sweep_sequencer_if b10();
  mux_sweep_sequencer_if b1();

  assign b10.y_in = mask10[{b10.a, b10.b, b10.c}];
  assign b1.y_in  = mask1[{b1.a, b1.b, b1.c}];

  mux_sweep_sequencer #(.HOLD_CYCLES(10), .HOLD_W(8)) dut10 (
    .clk(clk), .rst_n(rst_n), .bus(b10.slave));
  mux_sweep_sequencer #(.HOLD_CYCLES(1), .HOLD_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));

  typedef struct {
    logic [7:0] mask;
    logic [7:0] exp_truth;
    int         exp_lat;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] abc(input bit s);
    return s ? {b1.a, b1.b, b1.c} : {b10.a, b10.b, b10.c};
  endfunction
  function automatic logic done_of(input bit s);
    return s ? b1.done : b10.done;
  endfunction
  function automatic logic busy_of(input bit s);
    return s ? b1.busy : b10.busy;
  endfunction
  function automatic logic [7:0] truth_of(input bit s);
    return s ? b1.truth : b10.truth;
  endfunction
  function automatic logic valid_of(input bit s);
    return s ? b1.valid : b10.valid;
  endfunction

  // Expected combination on {a,b,c} after the n-th edge following the start edge.
  function automatic int exp_idx(input int n, input int h, input int abort_k);
    if (abort_k > 0 && abort_k <= 8 * h && n >= abort_k) return 0;
    if (n < 8 * h) return n / h;
    if (n == 8 * h) return 7;
    return 0;
  endfunction

  // One start pulse, optional abort sampled on edge abort_k (0 = none).
  task automatic run_sweep(input bit s, input logic [7:0] m, input int abort_k,
                           input int max_cyc, output int done_at, output int ndone,
                           output int abc_err);
    int h;
    h = s ? 1 : 10;
    if (s) begin mask1 = m; b1.start = 1'b1; end
    else   begin mask10 = m; b10.start = 1'b1; end
    step();
    b1.start = 1'b0; b10.start = 1'b0;
    done_at = -1; ndone = 0; abc_err = 0;
    if (int'(abc(s)) != exp_idx(0, h, abort_k)) abc_err++;
    for (int n = 1; n <= max_cyc; n++) begin
      if (n == abort_k) begin if (s) b1.abort = 1'b1; else b10.abort = 1'b1; end
      step();
      b1.abort = 1'b0; b10.abort = 1'b0;
      if (done_of(s)) begin
        ndone++;
        if (done_at < 0) done_at = n;
      end
      if (int'(abc(s)) != exp_idx(n, h, abort_k)) abc_err++;
    end
  endtask

  initial begin
    int done_at, ndone, aerr, cnt, errs, last_done, nd;
    bit prev_zero;
    logic [7:0] model_truth, m;
    int ak;
    bit exp_done;

    rst_n = 1'b0;
    b10.start = 0; b10.abort = 0; b10.loop = 0;
    b1.start = 0;  b1.abort = 0;  b1.loop = 0;
    mask10 = 8'h00; mask1 = 8'h00;
    #3;
    chk("reset_abc",   {29'd0, abc(0)}, 32'd0);
    chk("reset_busy",  {31'd0, b10.busy}, 32'd0);
    chk("reset_done",  {31'd0, b10.done}, 32'd0);
    chk("reset_truth", {24'd0, b10.truth}, 32'h00);
    chk("reset_valid", {31'd0, b10.valid}, 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (b10.busy || b10.done || abc(0) != 3'd0 || b1.busy) cnt++;
    end
    chk("idle_hold", cnt, 0);

    // Full sweep, majority function.
    run_sweep(0, 8'hE8, 0, 95, done_at, ndone, aerr);
    chk("sweep_done_at", done_at, 81);
    chk("sweep_ndone", ndone, 1);
    chk("sweep_truth", {24'd0, b10.truth}, 32'hE8);
    chk("sweep_valid", {31'd0, b10.valid}, 32'd1);
    chk("sweep_busy_end", {31'd0, b10.busy}, 32'd0);
    chk("sweep_abc", aerr, 0);

    // Abort at cycle 35 with xor function, then a clean xor sweep.
    run_sweep(0, 8'h96, 35, 120, done_at, ndone, aerr);
    chk("abort_ndone", ndone, 0);
    chk("abort_truth", {24'd0, b10.truth}, 32'hE8);
    chk("abort_valid", {31'd0, b10.valid}, 32'd1);
    chk("abort_abc", aerr, 0);
    run_sweep(0, 8'h96, 0, 95, done_at, ndone, aerr);
    chk("xor_truth", {24'd0, b10.truth}, 32'h96);
    chk("xor_done_at", done_at, 81);

    // Abort boundaries: last DRIVE cycle kills, DONE cycle lets the pulse through.
    run_sweep(0, 8'h3C, 80, 95, done_at, ndone, aerr);
    chk("abort80_ndone", ndone, 0);
    chk("abort80_truth", {24'd0, b10.truth}, 32'h96);
    run_sweep(0, 8'h3C, 81, 95, done_at, ndone, aerr);
    chk("abort81_ndone", ndone, 1);
    chk("abort81_truth", {24'd0, b10.truth}, 32'h3C);
    chk("abort81_abc", aerr, 0);

    // Table-driven sweeps on the single-cycle-dwell instance.
    vecs[0] = '{mask: 8'h00, exp_truth: 8'h00, exp_lat: 9};
    vecs[1] = '{mask: 8'hFF, exp_truth: 8'hFF, exp_lat: 9};
    vecs[2] = '{mask: 8'h55, exp_truth: 8'h55, exp_lat: 9};
    vecs[3] = '{mask: 8'h0F, exp_truth: 8'h0F, exp_lat: 9};
    vecs[4] = '{mask: 8'h81, exp_truth: 8'h81, exp_lat: 9};
    vecs[5] = '{mask: 8'hAA, exp_truth: 8'hAA, exp_lat: 9};
    foreach (vecs[i]) begin
      run_sweep(1, vecs[i].mask, 0, 15, done_at, ndone, aerr);
      chk($sformatf("vec%0d_truth", i), {24'd0, b1.truth}, {24'd0, vecs[i].exp_truth});
      chk($sformatf("vec%0d_lat", i), done_at, vecs[i].exp_lat);
      chk($sformatf("vec%0d_abc", i), aerr, 0);
    end

    // Loop mode with start held high: done every 9 cycles, truth AA each time.
    mask1 = 8'hAA; b1.loop = 1'b1; b1.start = 1'b1;
    step();
    prev_zero = 1'b0; errs = 0; cnt = 0; nd = 0; last_done = 0; done_at = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (abc(1) == 3'd0 && prev_zero) cnt++;
      prev_zero = (abc(1) == 3'd0);
      if (b1.done) begin
        if (done_at < 0) done_at = n;
        else if (n - last_done != 9) errs++;
        if (b1.truth !== 8'hAA) errs++;
        last_done = n;
        nd++;
      end
    end
    chk("loop_first_done", done_at, 9);
    chk("loop_ndone", nd, 4);
    chk("loop_period_truth", errs, 0);
    chk("loop_no_double_zero", cnt, 0);
    b1.start = 1'b0; b1.loop = 1'b0;
    repeat (12) step();
    chk("loop_exit_busy", {31'd0, b1.busy}, 32'd0);

    // Randomized sweeps with random abort points against a sweep-level model.
    model_truth = b10.truth;
    for (int t = 0; t < 12; t++) begin
      m  = 8'($urandom);
      ak = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 90)) : 0;
      exp_done = (ak == 0) || (ak > 80);
      if (exp_done) model_truth = m;
      run_sweep(0, m, ak, 95, done_at, ndone, aerr);
      chk($sformatf("rnd%0d_ndone", t), ndone, exp_done ? 1 : 0);
      chk($sformatf("rnd%0d_truth", t), {24'd0, b10.truth}, {24'd0, model_truth});
      chk($sformatf("rnd%0d_abc", t), aerr, 0);
      if (exp_done) chk($sformatf("rnd%0d_lat", t), done_at, 81);
    end

    // Asynchronous reset while idx==5.
    mask10 = 8'hE8; b10.start = 1'b1;
    step();
    b10.start = 1'b0;
    repeat (50) step();
    chk("ar_pre_abc", {29'd0, abc(0)}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_abc",   {29'd0, abc(0)}, 32'd0);
    chk("ar_busy",  {31'd0, b10.busy}, 32'd0);
    chk("ar_done",  {31'd0, b10.done}, 32'd0);
    chk("ar_truth", {24'd0, b10.truth}, 32'h00);
    chk("ar_valid", {31'd0, b10.valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    nd = 0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (b10.done || b10.busy) nd++;
    end
    chk("ar_quiet", nd, 0);
    chk("ar_valid_after", {31'd0, b10.valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_sweep_sequencer.md
Name: mux_sweep_sequencer

Overview:
- Upstream stimulus-and-capture stage for the 3-input mux (mux_4x1_ family): drives the mux's a, b, c select/data inputs and reads back its output y.
- On start, steps {a,b,c} through all 8 combinations, 0 to 7. Each combination is held for HOLD_CYCLES clocks.
- Samples the mux output at the end of each dwell and publishes an 8-bit truth vector with a done pulse.
- Replaces the open-loop testbench sweep with a synthesizable on-chip self-check source.

Parameters:
- HOLD_CYCLES, 10, dwell per combination in clocks; legal range 1..255.
- HOLD_W, 8, width of dwell counter; must satisfy 2**HOLD_W > HOLD_CYCLES-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level-sampled request to begin a sweep; honoured only in IDLE.
- abort  in  1  cancel current sweep; priority over start.
- loop  in  1  when 1 at end of sweep, restart at combination 0 without returning to IDLE.
- y_in  in  1  mux output y, combinationally derived from a,b,c.
- a  out  1  mux input, MSB of combination index.
- b  out  1  mux input, middle bit.
- c  out  1  mux input, LSB.
- busy  out  1  high in DRIVE and DONE.
- done  out  1  one-cycle pulse when truth is updated.
- truth  out  8  bit i = y_in sampled while {a,b,c}==i.
- valid  out  1  truth holds a complete sweep; sticky.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n), with a synchronous deassert assumed at top level.
- Reset values: a=b=c=0, busy=0, done=0, truth=8'h00, valid=0, state=IDLE, idx=0, hold_cnt=0, shadow=8'h00.
- Outputs: all are registered; {a,b,c} is driven directly from the registered idx.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - {a,b,c}=000.
  - If abort, stay in IDLE.
  - Else if start, go to DRIVE with idx=0 and hold_cnt=0.
- DRIVE:
  - {a,b,c}=idx. hold_cnt increments each cycle.
  - When hold_cnt==HOLD_CYCLES-1: shadow[idx] <= y_in.
    - If idx==7, go to DONE.
    - Else idx <= idx+1 and hold_cnt <= 0.
- DONE (exactly one cycle):
  - truth <= shadow, including the final sample written on the transition edge.
  - done=1 and valid <= 1.
  - Next state: if loop, DRIVE with idx=0 and hold_cnt=0; else IDLE with {a,b,c}=000.
- Latency: from the edge that samples start=1 to the done pulse is 8*HOLD_CYCLES+1 cycles. The first combination is visible on a,b,c on the cycle after the start edge.
- Sample point: the last cycle of each dwell. y_in must settle within HOLD_CYCLES clocks. With HOLD_CYCLES=1, every cycle is a sample cycle.
- abort (in DRIVE or DONE):
  - Next edge goes to IDLE.
  - shadow is discarded; truth and valid are unchanged.
  - done does not pulse. An abort arriving in the DONE cycle still lets that done pulse complete, then goes to IDLE regardless of loop.
- start while busy is ignored; there is no queuing.
- valid is never cleared except by reset. truth keeps the previous sweep until the next done.
- Async reset mid-sweep forces all outputs to their reset values immediately, without waiting for clk.
- idx is 3 bits. The 7-to-0 wrap happens only through DONE, never by overflow.

Decomposition:
- Shared package mux_seq_pkg:
  - state encoding constants: IDLE=2'd0, DRIVE=2'd1, DONE=2'd2.
  - NUM_COMB=8 and IDX_W=3.
- Sub-module dwell_counter (parameter HOLD_CYCLES):
  - inputs clk, rst_n, clear, en.
  - output last, high when count==HOLD_CYCLES-1 and en.
  - The FSM uses last to advance idx and strobe shadow.

Test Plan:
- Reset check: hold rst_n=0 -> a,b,c=000, busy=0, done=0, truth=8'h00, valid=0. Release, no start -> state stays IDLE for 50 cycles.
- Full sweep: HOLD_CYCLES=10, y_in modelled as majority(a,b,c), start pulse -> a,b,c steps 000..111 every 10 cycles. done pulses exactly 81 cycles after the start edge, with truth=8'hE8 and valid=1. busy returns to 0.
- Abort: abort at cycle 35 of a second sweep using y_in=a^b^c -> IDLE next edge. No done pulse, truth stays 8'hE8, valid=1. A following sweep with y_in=a^b^c yields truth=8'h96.
- Start while busy plus loop: start held high throughout and loop=1, HOLD_CYCLES=1, y_in=c -> done pulses every 9 cycles, truth=8'hAA each time, a,b,c never reads 000 for 2 consecutive cycles.
- Async reset mid-op: drop rst_n between clk edges at idx=5 -> outputs return to reset values before the next clk edge. No done pulse, valid=0.
